// File: rtl/alu_mul_seq_pkg.sv
// rtl/alu_mul_seq_pkg.sv - shared ALU encodings, widths and sequencer state codes
//
// Purpose : constants shared by the multiply sequencer, its bus interface and
//           anything that talks to the shared ALU.
// Ports   : none (package).
package alu_mul_seq_pkg;

   typedef logic [3:0] alu_oper_t;

   localparam int MUL_WIDTH = 16;
   localparam int MUL_CNT_W = 4;

   // ALU Oper encodings
   localparam alu_oper_t ALU_ROL = 4'b0000;
   localparam alu_oper_t ALU_SLL = 4'b0001;
   localparam alu_oper_t ALU_ROR = 4'b0010;
   localparam alu_oper_t ALU_SRL = 4'b0011;
   localparam alu_oper_t ALU_ADD = 4'b0100;
   localparam alu_oper_t ALU_AND = 4'b0101;
   localparam alu_oper_t ALU_OR  = 4'b0110;
   localparam alu_oper_t ALU_XOR = 4'b0111;
   localparam alu_oper_t ALU_SEQ = 4'b1000;
   localparam alu_oper_t ALU_SLT = 4'b1001;
   localparam alu_oper_t ALU_SLE = 4'b1010;
   localparam alu_oper_t ALU_BTR = 4'b1111;

   // Sequencer state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - request/response handshake bundle for the multiply sequencer
//
// Purpose : groups the operand request and product response handshakes.
// Signals : in_valid/in_ready/op_a/op_b   request channel
//           out_valid/out_ready/result    product channel
// Modports: master = requester/consumer side, slave = sequencer side.
interface alu_mul_seq_if
   import alu_mul_seq_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output in_valid, op_a, op_b, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, op_a, op_b, out_ready,
      output in_ready, out_valid, result
   );

endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative 16x16 unsigned shift-and-add multiplier on the shared ALU
//
// Purpose : computes op_a*op_b in 16 RUN cycles, using an external ALU for every
//           addition, and returns the 32-bit product through a valid/ready handshake.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           bus (slave)         in_valid/in_ready/op_a/op_b, out_valid/out_ready/result
//           alu_InA..alu_sign   operand/control pins driven to the shared ALU
//           alu_Out, alu_Ofl    ALU sum and unsigned carry-out (sign=0)
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int        WIDTH    = MUL_WIDTH,
   parameter logic [3:0] OPER_ADD = ALU_ADD,
   parameter int        CNT_W    = MUL_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_mul_seq_if.slave       bus,
   output logic [WIDTH-1:0]   alu_InA,
   output logic [WIDTH-1:0]   alu_InB,
   output logic               alu_Cin,
   output logic [3:0]         alu_Oper,
   output logic               alu_invA,
   output logic               alu_invB,
   output logic               alu_sign,
   input  logic [WIDTH-1:0]   alu_Out,
   input  logic               alu_Ofl
);

   logic [1:0]        state_q, state_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic running;
   assign running = (state_q == ST_RUN);

   // Moore outputs: everything below is decoded from registers only.
   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = {hi_q, lo_q};

   // Outside RUN the ALU sees zero operands with Oper parked at ADD.
   assign alu_InA  = running ? hi_q : '0;
   assign alu_InB  = (running && lo_q[0]) ? mcand_q : '0;
   assign alu_Oper = OPER_ADD;
   assign alu_Cin  = 1'b0;
   assign alu_invA = 1'b0;
   assign alu_invB = 1'b0;
   assign alu_sign = 1'b0;

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               mcand_d = bus.op_a;
               hi_d    = '0;
               lo_d    = bus.op_b;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // The carry-out becomes the new top bit; the whole 2*WIDTH+1 value
            // shifts right by one, consuming the multiplier bit just used.
            {hi_d, lo_d} = {alu_Ofl, alu_Out, lo_q[WIDTH-1:1]};
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
